// File: rtl/deser7_pkg.sv
// deser7_pkg: shared word/counter sizing for the 7-bit serial capture macro.
package deser7_pkg;
  localparam int WORD_W = 7;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd6;
endpackage

// File: rtl/deser7.sv
// deser7: serial-to-parallel capture, one bit per enabled CK, 7-bit word on
// Q0..Q6 with a one-cycle QV strobe. Q0 holds the first bit received.
// Optional: define DESER7_ZERO_FLAG_EN to add ZN0, the all-zero (7-input NOR)
// flag of the output word.
module deser7
  import deser7_pkg::*;
(
  input  logic CK,
  input  logic RST,
  input  logic SI,
  input  logic EN,
  input  logic SYNC,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic Q4,
  output logic Q5,
  output logic Q6,
  output logic QV
`ifdef DESER7_ZERO_FLAG_EN
  ,
  output logic ZN0
`endif
);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-2:0] sr;   // bits 0..5 of the word in progress
  logic [WORD_W-1:0] q;
  logic              qv;

  // Bit accumulation, word completion and boundary restart; QV is a pulse.
  always_ff @(posedge CK) begin
    if (RST) begin
      cnt <= '0;
      sr  <= '0;
      q   <= '0;
      qv  <= 1'b0;
    end else begin
      qv <= 1'b0;
      if (SYNC) begin
        // Drop the partial word; an accepted bit in this cycle is bit 0.
        if (EN) begin
          sr[0] <= SI;
          cnt   <= CNT_W'(1);
        end else begin
          cnt <= '0;
        end
      end else if (EN) begin
        if (cnt == CNT_LAST) begin
          q   <= {SI, sr};
          cnt <= '0;
          qv  <= 1'b1;
        end else begin
          for (int i = 0; i < WORD_W-1; i++)
            if (cnt == i[CNT_W-1:0]) sr[i] <= SI;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign {Q6, Q5, Q4, Q3, Q2, Q1, Q0} = q;
  assign QV = qv;

`ifdef DESER7_ZERO_FLAG_EN
  assign ZN0 = ~|q;
`endif

endmodule

// File: tb/tb_deser7.sv
// tb_deser7: randomized and directed checks of deser7 against a queue-based
// word-assembly model.
module tb_deser7;
  logic CK = 1'b0, RST = 1'b1, SI = 1'b0, EN = 1'b0, SYNC = 1'b0;
  logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, QV;
`ifdef DESER7_ZERO_FLAG_EN
  logic ZN0;
`endif
  logic [6:0] q;
  assign q = {Q6, Q5, Q4, Q3, Q2, Q1, Q0};

  deser7 dut (
    .CK(CK), .RST(RST), .SI(SI), .EN(EN), .SYNC(SYNC),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .QV(QV)
`ifdef DESER7_ZERO_FLAG_EN
    , .ZN0(ZN0)
`endif
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted bits collected in arrival order.
  bit         mq[$];
  logic [6:0] exp_q  = '0;
  logic       exp_qv = 1'b0;

  // Drive one cycle, advance the model at the edge, sample 1 time unit later.
  task automatic cyc(input logic si, input logic en, input logic sync, input logic rst);
    SI = si; EN = en; SYNC = sync; RST = rst;
    @(posedge CK);
    exp_qv = 1'b0;
    if (rst) begin
      mq.delete();
      exp_q = '0;
    end else begin
      if (sync) mq.delete();
      if (en) begin
        mq.push_back(si);
        if (mq.size() == 7) begin
          for (int i = 0; i < 7; i++) exp_q[i] = mq[i];
          mq.delete();
          exp_qv = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (q !== 7'd0) begin errors++; $display("FAIL reset_q got=%b want=0000000", q); end
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL reset_qv got=%b want=0", QV); end
`ifdef DESER7_ZERO_FLAG_EN
    checks++; if (ZN0 !== 1'b1) begin errors++; $display("FAIL reset_zn0 got=%b want=1", ZN0); end
`endif
    RST = 1'b0;
  endtask

  task automatic test_word();
    logic [6:0] bits = 7'b1001101;  // bit i is the i-th serial bit
    for (int i = 0; i < 7; i++) begin
      cyc(bits[i], 1'b1, 1'b0, 1'b0);
      checks++; if (QV !== (i == 6)) begin errors++; $display("FAIL word_qv bit=%0d got=%b want=%b", i, QV, (i == 6)); end
    end
    checks++; if (q !== 7'b1001101) begin errors++; $display("FAIL word_q got=%b want=1001101", q); end
`ifdef DESER7_ZERO_FLAG_EN
    checks++; if (ZN0 !== 1'b0) begin errors++; $display("FAIL word_zn0 got=%b want=0", ZN0); end
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (QV !== 1'b0 || q !== 7'b1001101) begin errors++; $display("FAIL word_hold q=%b qv=%b want q=1001101 qv=0", q, QV); end
  endtask

  task automatic test_zero();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (q !== 7'b1111111 || QV !== 1'b1) begin errors++; $display("FAIL ones_word q=%b qv=%b want q=1111111 qv=1", q, QV); end
`ifdef DESER7_ZERO_FLAG_EN
    checks++; if (ZN0 !== 1'b0) begin errors++; $display("FAIL ones_zn0 got=%b want=0", ZN0); end
`endif
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (q !== 7'b0000000 || QV !== 1'b1) begin errors++; $display("FAIL zeros_word q=%b qv=%b want q=0000000 qv=1", q, QV); end
`ifdef DESER7_ZERO_FLAG_EN
    checks++; if (ZN0 !== 1'b1) begin errors++; $display("FAIL zeros_zn0 got=%b want=1", ZN0); end
`endif
  endtask

  task automatic test_en_toggle();
    logic [6:0] bits = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      cyc(bits[i], 1'b1, 1'b0, 1'b0);
      checks++; if (QV !== (i == 6)) begin errors++; $display("FAIL entog_qv bit=%0d got=%b want=%b", i, QV, (i == 6)); end
      if (i != 6) begin
        cyc(~bits[i], 1'b0, 1'b0, 1'b0);
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL entog_idle_qv bit=%0d got=%b want=0", i, QV); end
      end
    end
    checks++; if (q !== 7'b1010101) begin errors++; $display("FAIL entog_q got=%b want=1010101", q); end
  endtask

  task automatic test_sync();
    logic [6:0] prev = q;
    logic [6:0] bits = 7'b0000111;  // serial order 1,1,1,0,0,0,0
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(bits[i], 1'b1, (i == 0), 1'b0);
      if (i < 6) begin
        checks++; if (QV !== 1'b0 || q !== prev) begin errors++; $display("FAIL sync_hold bit=%0d q=%b qv=%b want q=%b qv=0", i, q, QV, prev); end
      end
    end
    checks++; if (q !== 7'b0000111 || QV !== 1'b1) begin errors++; $display("FAIL sync_word q=%b qv=%b want q=0000111 qv=1", q, QV); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (q !== 7'd0 || QV !== 1'b0) begin errors++; $display("FAIL rstmid q=%b qv=%b want q=0000000 qv=0", q, QV); end
`ifdef DESER7_ZERO_FLAG_EN
    checks++; if (ZN0 !== 1'b1) begin errors++; $display("FAIL rstmid_zn0 got=%b want=1", ZN0); end
`endif
    for (int i = 0; i < 7; i++) cyc((i == 1 || i == 5), 1'b1, 1'b0, 1'b0);
    checks++; if (q !== 7'b0100010 || QV !== 1'b1) begin errors++; $display("FAIL rstmid_word q=%b qv=%b want q=0100010 qv=1", q, QV); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = -100;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      cyc($urandom_range(0, 1), 1'b1, 1'b0, 1'b0);
      checks++; if (q !== exp_q || QV !== exp_qv) begin errors++; $display("FAIL b2b cyc=%0d q=%b qv=%b want q=%b qv=%b", i, q, QV, exp_q, exp_qv); end
      if (QV === 1'b1) begin
        if (pulses > 0) begin
          checks++; if (i - last != 7) begin errors++; $display("FAIL b2b_spacing got=%0d want=7", i - last); end
        end
        pulses++;
        last = i;
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
  endtask

  task automatic test_random();
    logic prev_qv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 63) == 0));
      checks++; if (q !== exp_q || QV !== exp_qv) begin errors++; $display("FAIL rand cyc=%0d q=%b qv=%b want q=%b qv=%b", i, q, QV, exp_q, exp_qv); end
`ifdef DESER7_ZERO_FLAG_EN
      checks++; if (ZN0 !== (exp_q == 7'd0)) begin errors++; $display("FAIL rand_zn0 cyc=%0d got=%b want=%b", i, ZN0, (exp_q == 7'd0)); end
`endif
      if (prev_qv === 1'b1) begin
        checks++; if (QV !== 1'b0) begin errors++; $display("FAIL rand_qv_double cyc=%0d got=%b want=0", i, QV); end
      end
      prev_qv = QV;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_zero();
    test_en_toggle();
    test_sync();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
